mem_rd_arb: RTL and testbench

//  NUM_CH-channel read arbiter: multiplexes NUM_CH client read ports onto one memory read port.

---
 rtl/mem_rd_arb.sv | 149 ++++++++++++++
 tb/tb_mem_rd_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arb.sv
// Round-robin read arbiter: NUM_CH client read ports share one memory read port, grant held per transfer.
// Optional per-channel line counters are enabled by defining MEM_RD_ARB_STATS_EN.
module mem_rd_arb #(
  parameter int NUM_CH            = 4,
  parameter int WORD_WIDTH        = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int ADDR_WIDTH        = 19,
  localparam int LINE_W = NUM_WORDS_IN_LINE * WORD_WIDTH,
  localparam int LV_W   = $clog2(NUM_WORDS_IN_LINE * WORD_WIDTH / 8),
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            cl_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cl_start_addr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cl_size_bytes,
  output logic [NUM_CH-1:0]            cl_valid,
  output logic [NUM_CH-1:0]            cl_last,
  output logic [LINE_W-1:0]            cl_data,
  output logic [LV_W-1:0]              cl_last_valid,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_start_addr,
  output logic [ADDR_WIDTH-1:0]        mem_size_bytes,
  input  logic                         mem_valid,
  input  logic                         mem_last,
  input  logic [LINE_W-1:0]            mem_data,
  input  logic [LV_W-1:0]              mem_last_valid,
`ifdef MEM_RD_ARB_STATS_EN
  input  logic                         stats_clr,
  output logic [NUM_CH*16-1:0]         stats_lines,
`endif
  output logic [CH_W-1:0]              grant_id,
  output logic                         arb_err
);

  typedef enum logic [1:0] {IDLE, BUSY, LOCAL, RELEASE} state_t;

  state_t                state;
  logic [CH_W-1:0]       rr_ptr;
  logic                  found;
  logic [CH_W-1:0]       pick_id;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [ADDR_WIDTH-1:0] pick_size;

  // First requester at or after rr_ptr, wrapping at NUM_CH.
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && cl_req[(int'(rr_ptr) + i) % NUM_CH]) begin
        found   = 1'b1;
        pick_id = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  assign pick_addr = cl_start_addr[int'(pick_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_size = cl_size_bytes[int'(pick_id)*ADDR_WIDTH +: ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_id       <= '0;
      mem_req        <= 1'b0;
      mem_start_addr <= '0;
      mem_size_bytes <= '0;
      arb_err        <= 1'b0;
    end else begin
      // Memory lines outside a transfer have no owner: dropped and flagged.
      if (mem_valid && state != BUSY)
        arb_err <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id       <= pick_id;
            mem_start_addr <= pick_addr;
            mem_size_bytes <= pick_size;
            if (pick_size != '0) begin
              state   <= BUSY;
              mem_req <= 1'b1;
            end else begin
              state <= LOCAL;
            end
          end
        end
        BUSY: begin
          if (mem_valid && mem_last) begin
            state   <= RELEASE;
            mem_req <= 1'b0;
          end
        end
        LOCAL: state <= RELEASE;
        RELEASE: begin
          rr_ptr <= (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + CH_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path is combinational so memory lines reach the client with zero latency.
  always_comb begin
    cl_valid      = '0;
    cl_last       = '0;
    cl_data       = '0;
    cl_last_valid = '0;
    case (state)
      BUSY: begin
        cl_valid[grant_id] = mem_valid;
        cl_last[grant_id]  = mem_valid & mem_last;
        cl_data            = mem_data;
        cl_last_valid      = mem_last_valid;
      end
      LOCAL: begin
        cl_valid[grant_id] = 1'b1;
        cl_last[grant_id]  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MEM_RD_ARB_STATS_EN
  logic [15:0] line_cnt [NUM_CH];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) line_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stats_clr)
          line_cnt[i] <= '0;
        else if (cl_valid[i])
          line_cnt[i] <= sat_inc(line_cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
    assign stats_lines[g*16 +: 16] = line_cnt[g];
  end
`endif

endmodule

// File: tb/tb_mem_rd_arb.sv
// Directed bench for mem_rd_arb: expected client lines are queued when stimulus is driven and
// compared when the arbiter presents them.
module tb_mem_rd_arb;
  localparam int NUM_CH = 4;
  localparam int AW     = 19;
  localparam int LW     = 256;
  localparam int LVW    = 5;
  localparam int CHW    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_CH-1:0]      cl_req;
  logic [NUM_CH*AW-1:0]   cl_start_addr;
  logic [NUM_CH*AW-1:0]   cl_size_bytes;
  logic [NUM_CH-1:0]      cl_valid;
  logic [NUM_CH-1:0]      cl_last;
  logic [LW-1:0]          cl_data;
  logic [LVW-1:0]         cl_last_valid;
  logic                   mem_req;
  logic [AW-1:0]          mem_start_addr;
  logic [AW-1:0]          mem_size_bytes;
  logic                   mem_valid;
  logic                   mem_last;
  logic [LW-1:0]          mem_data;
  logic [LVW-1:0]         mem_last_valid;
  logic [CHW-1:0]         grant_id;
  logic                   arb_err;
`ifdef MEM_RD_ARB_STATS_EN
  logic                   stats_clr;
  logic [NUM_CH*16-1:0]   stats_lines;
`endif

  always #5 clk = ~clk;

  mem_rd_arb dut (
    .clk(clk), .rst_n(rst_n),
    .cl_req(cl_req), .cl_start_addr(cl_start_addr), .cl_size_bytes(cl_size_bytes),
    .cl_valid(cl_valid), .cl_last(cl_last), .cl_data(cl_data), .cl_last_valid(cl_last_valid),
    .mem_req(mem_req), .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
    .mem_valid(mem_valid), .mem_last(mem_last), .mem_data(mem_data), .mem_last_valid(mem_last_valid),
`ifdef MEM_RD_ARB_STATS_EN
    .stats_clr(stats_clr), .stats_lines(stats_lines),
`endif
    .grant_id(grant_id), .arb_err(arb_err)
  );

  typedef struct {
    int            ch;
    logic          last;
    logic [LW-1:0] data;
    logic [LVW-1:0] lv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk(input int k);
    logic [31:0] w;
    w = 32'h5A5A_0000 ^ k;
    return {8{w}};
  endfunction

  task automatic push(input int ch, input logic last, input logic [LW-1:0] d, input logic [LVW-1:0] lv);
    exp_t e;
    e.ch = ch; e.last = last; e.data = d; e.lv = lv;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    logic [NUM_CH-1:0] onehot;
    chk({tag, "_sb_nonempty"}, LW'(sb.size() != 0), LW'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      onehot = NUM_CH'(1) << e.ch;
      chk({tag, "_valid"}, LW'(cl_valid), LW'(onehot));
      chk({tag, "_last"}, LW'(cl_last), e.last ? LW'(onehot) : LW'(0));
      chk({tag, "_data"}, cl_data, e.data);
      chk({tag, "_lv"}, LW'(cl_last_valid), LW'(e.lv));
    end
  endtask

  task automatic mem_line(input string tag, input logic [LW-1:0] d, input logic lst, input logic [LVW-1:0] lv);
    mem_valid = 1'b1; mem_last = lst; mem_data = d; mem_last_valid = lv;
    #1;
    check_out(tag);
    tick();
    mem_valid = 1'b0; mem_last = 1'b0; mem_data = '0; mem_last_valid = '0;
  endtask

  task automatic wait_req(input string tag, input int exp_n);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, LW'(n), LW'(exp_n));
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [AW-1:0] s);
    cl_start_addr[ch*AW +: AW] = a;
    cl_size_bytes[ch*AW +: AW] = s;
  endtask

  initial begin
    rst_n = 1'b0; cl_req = '0; cl_start_addr = '0; cl_size_bytes = '0;
    mem_valid = 1'b0; mem_last = 1'b0; mem_data = '0; mem_last_valid = '0;
`ifdef MEM_RD_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_mem_req", LW'(mem_req), LW'(0));
    chk("rst_grant", LW'(grant_id), LW'(0));
    chk("rst_addr", LW'(mem_start_addr), LW'(0));
    chk("rst_size", LW'(mem_size_bytes), LW'(0));
    chk("rst_err", LW'(arb_err), LW'(0));
    chk("rst_cl_valid", LW'(cl_valid), LW'(0));
    chk("rst_cl_data", cl_data, LW'(0));
    rst_n = 1'b1;
    tick();

    // Single ch2 transfer of two lines.
    set_ch(2, 19'h100, 19'd64);
    cl_req = 4'b0100;
    push(2, 1'b0, mk(1), 5'd0);
    push(2, 1'b1, mk(2), 5'd31);
    wait_req("t1_req_lat", 1);
    chk("t1_grant", LW'(grant_id), LW'(2));
    chk("t1_addr", LW'(mem_start_addr), LW'(19'h100));
    chk("t1_size", LW'(mem_size_bytes), LW'(64));
    chk("t1_idle_valid", LW'(cl_valid), LW'(0));
    mem_line("t1_l0", mk(1), 1'b0, 5'd0);
    mem_line("t1_l1", mk(2), 1'b1, 5'd31);
    chk("t1_req_drop", LW'(mem_req), LW'(0));
    chk("t1_rel_data", cl_data, LW'(0));
    cl_req = '0;
    tick();

    // All four request together from reset; ch0 stays requesting and is served again.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NUM_CH; k++) set_ch(k, AW'(19'h1000 * (k + 1)), 19'd32);
    cl_req = 4'b1111;
    for (int k = 0; k < NUM_CH; k++) begin
      push(k, 1'b1, mk(10 + k), 5'd31);
      wait_req($sformatf("t2_lat%0d", k), (k == 0) ? 1 : 2);
      chk($sformatf("t2_grant%0d", k), LW'(grant_id), LW'(k));
      chk($sformatf("t2_addr%0d", k), LW'(mem_start_addr), LW'(19'h1000 * (k + 1)));
      mem_line($sformatf("t2_l%0d", k), mk(10 + k), 1'b1, 5'd31);
      if (k != 0) cl_req[k] = 1'b0;
    end
    push(0, 1'b1, mk(20), 5'd7);
    wait_req("t2_regrant_lat", 2);
    chk("t2_regrant", LW'(grant_id), LW'(0));
    cl_req[0] = 1'b0;
    mem_line("t2_drop_busy", mk(20), 1'b1, 5'd7);
    repeat (5) tick();
    chk("t2_no_regrant", LW'(mem_req), LW'(0));

    // Zero-size request on ch1 completes locally.
    set_ch(1, 19'h200, 19'd0);
    cl_req = 4'b0010;
    #1;
    chk("t3_pre_valid", LW'(cl_valid), LW'(0));
    push(1, 1'b1, LW'(0), 5'd0);
    tick();
    check_out("t3_local");
    chk("t3_grant", LW'(grant_id), LW'(1));
    chk("t3_mem_req", LW'(mem_req), LW'(0));
    tick();
    cl_req = '0;
    chk("t3_rel_valid", LW'(cl_valid), LW'(0));
    chk("t3_rel_mem_req", LW'(mem_req), LW'(0));
    tick();

    // Stray memory line while idle.
    chk("t4_err_before", LW'(arb_err), LW'(0));
    mem_valid = 1'b1; mem_data = mk(99); mem_last = 1'b1;
    #1;
    chk("t4_no_valid", LW'(cl_valid), LW'(0));
    chk("t4_no_data", cl_data, LW'(0));
    tick();
    mem_valid = 1'b0; mem_data = '0; mem_last = 1'b0;
    chk("t4_err_set", LW'(arb_err), LW'(1));
    repeat (3) tick();
    chk("t4_err_held", LW'(arb_err), LW'(1));

    // Reset in the middle of an eight-line transfer.
    set_ch(3, 19'h400, 19'd256);
    cl_req = 4'b1000;
    wait_req("t5_req_lat", 1);
    chk("t5_grant", LW'(grant_id), LW'(3));
    for (int k = 0; k < 3; k++) push(3, 1'b0, mk(30 + k), 5'd0);
    mem_line("t5_l0", mk(30), 1'b0, 5'd0);
    mem_line("t5_l1", mk(31), 1'b0, 5'd0);
    mem_valid = 1'b1; mem_data = mk(32);
    #1;
    check_out("t5_l2");
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_req", LW'(mem_req), LW'(0));
    chk("t5_rst_valid", LW'(cl_valid), LW'(0));
    chk("t5_rst_data", cl_data, LW'(0));
    chk("t5_rst_err", LW'(arb_err), LW'(0));
    chk("t5_rst_grant", LW'(grant_id), LW'(0));
    mem_valid = 1'b0; mem_data = '0;
    set_ch(0, 19'h800, 19'd32);
    cl_req = 4'b1001;
    tick();
    rst_n = 1'b1;
    wait_req("t5_fresh_lat", 1);
    chk("t5_fresh_grant", LW'(grant_id), LW'(0));
    chk("t5_fresh_addr", LW'(mem_start_addr), LW'(19'h800));
    push(0, 1'b1, mk(40), 5'd3);
    mem_line("t5_fresh_l0", mk(40), 1'b1, 5'd3);
    cl_req = '0;
    tick();
    tick();

`ifdef MEM_RD_ARB_STATS_EN
    set_ch(3, 19'h0, 19'h7FFFF);
    cl_req = 4'b1000;
    wait_req("t6_req_lat", 1);
    cl_req = '0;
    mem_valid = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      mem_last = (k == 69999);
      tick();
    end
    mem_valid = 1'b0; mem_last = 1'b0;
    chk("t6_sat", LW'(stats_lines[3*16 +: 16]), LW'(16'hFFFF));
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("t6_clr", LW'(stats_lines[3*16 +: 16]), LW'(0));
`endif

    chk("sb_drained", LW'(sb.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
